ahblite_sram: RTL and testbench
===============================

# ahblite_sram

AHB-Lite slave that answers the core's `ibus`/`dbus` master ports with a single-clock, word-organised on-chip SRAM. It decodes address-phase controls, performs byte/halfword/word reads and writes with AHB-correct data-phase timing, and inserts a configurable number of wait states. It forwards write data to an immediately following read, and returns the two-cycle ERROR response for illegal transfers. One instance serves instruction RAM, another serves data RAM.

## Interface
- `AW`, 16: byte address width. Array depth is 2^(AW-2) 32-bit words.
- `WAIT_STATES`, 0: number of `hreadyout`-low cycles inserted into each OKAY data phase (0–15).
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `ahb_hsel` in 1: slave select.
- `ahb_haddr` in AW: byte address.
- `ahb_htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `ahb_hwrite` in 1: 1 = write.
- `ahb_hsize` in 3: 0 = byte, 1 = half, 2 = word; 3–7 are illegal.
- `ahb_hburst`, `ahb_hport`, `ahb_hmastlock` in 3/4/1: accepted and ignored.
- `ahb_hwdata` in 32: write data, valid in the data phase.
- `ahb_hready` in 1: bus-level HREADY (end of the previous data phase).
- `ahb_hreadyout` out 1: slave ready.
- `ahb_hresp` out 1: 0 = OKAY, 1 = ERROR.
- `ahb_hrdata` out 32: read data.

## Operation
- Accept condition: `hsel & hready & htrans[1]`, sampled at the rising edge that ends the address phase. On accept, latch addr, size and write into data-phase registers.
- IDLE/BUSY, or not selected: no data phase. The slave stays at `hreadyout=1`, `hresp=0`.
- Illegal transfer, either of:
  - `hsize>2`
  - misaligned: size 1 with `haddr[0]=1`, or size 2 with `haddr[1:0]≠0`
- Illegal transfer response:
  - no array access
  - go to ERR1 (`hreadyout=0`, `hresp=1`), then ERR2 (`hreadyout=1`, `hresp=1`), then IDLE, or accept the next transfer in ERR2
  - WAIT_STATES do not apply.
- Byte lanes:
  - size 0 → lane `haddr[1:0]`
  - size 1 → lanes {1,0} or {3,2} selected by `haddr[1]`
  - size 2 → all lanes
  - data is lane-aligned as AHB requires; no shifting.
- State machine:
  - States are IDLE, WAIT, LAST, ERR1, ERR2.
  - A legal accept goes to WAIT with counter = WAIT_STATES when WAIT_STATES>0, else to LAST.
  - WAIT drives `hreadyout=0` and decrements; it goes to LAST when the counter is 1.
  - LAST drives `hreadyout=1`, `hresp=0`, and may accept a new transfer in the same cycle.
  - Accepts are legal only in IDLE, LAST and ERR2.
- Read: the array read is issued at accept. The result is registered and presented on `hrdata` for the whole data phase. `hrdata` holds its last read value at all other times.
- Write: `hwdata` is sampled and committed to the array with lane strobes at the edge ending LAST.
- Read-after-write forwarding: if a read is accepted at the same edge a write commits to the same word, `hrdata` returns array data with the committed lanes replaced by the new bytes.
- Reset mid-transaction: a pending write is dropped and the state goes to IDLE. Array contents are not reset.

## Timing
- Reset values: `hreadyout=1`, `hresp=0`, `hrdata=0`, state IDLE, counter 0.
- Address phase in cycle T: the data phase spans T+1 … T+1+WAIT_STATES. `hreadyout` is low for exactly WAIT_STATES cycles, then high for one.
- Read latency: `hrdata` is valid from cycle T+1 and is required to be stable through the cycle where `hreadyout=1`.
- Write: the array reflects the new data from cycle T+2+WAIT_STATES.
- Back-to-back: with WAIT_STATES=0, one transfer per cycle is sustained, including write→read of the same word.
- `hready` low from another slave: no accept, no state change.
- ERROR: exactly two cycles, `hresp` high in both; `hreadyout` is low in the first only.

## Test plan
- Word write then read, WAIT_STATES=0: write 0xDEADBEEF to 0x0010, then read 0x0010 in the next address phase → `hrdata`=0xDEADBEEF with zero wait, via the forwarding path. Re-read two cycles later → 0xDEADBEEF from the array.
- Byte/half lanes: after the above, byte write `haddr`=0x0011, `hwdata`=0x0000AA00 → read 0x0010 = 0xDEADAAEF. Half write `haddr`=0x0012, `hwdata`=0x12340000 → read 0x0010 = 0x1234AAEF.
- Wait states, WAIT_STATES=2: read 0x0020 holding 0x55AA55AA → `hreadyout` is 0 for 2 cycles then 1, `hrdata`=0x55AA55AA throughout the data phase. A write takes 3 data-phase cycles.
- Error: word read at 0x0002, then half write at 0x0005 → each gets `hreadyout` 0,1 with `hresp` 1,1. Memory is unchanged and `hrdata` holds its prior value.
- IDLE/BUSY/deselected cycles: `htrans`=1 with `hsel`=1, and `htrans`=2 with `hsel`=0 → `hreadyout`=1, `hresp`=0, no array write.
- Reset mid-write: assert `rst` in the data phase of a write of 0xCAFEF00D to 0x0030 → outputs return to reset values next cycle. Read 0x0030 → old contents.

Source files
------------

// File: rtl/ahblite_sram_if.sv
// AHB-Lite bus bundle between one master port and one SRAM slave.
interface ahblite_sram_if #(
  parameter int AW = 16
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hport;
  logic          hmastlock;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;

  // hready is the bus-level ready returned by the interconnect, so it travels with the master side.
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hport, hmastlock, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hport, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahblite_sram.sv
// AHB-Lite slave in front of a word-organised single-clock SRAM with byte lanes,
// programmable wait states, write-to-read forwarding and two-cycle ERROR responses.
module ahblite_sram #(
  parameter int AW          = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  ahblite_sram_if.slave  ahb
);

  localparam int DEPTH = 1 << (AW - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;

  logic          can_accept;
  logic          accept;
  logic          illegal;
  logic          commit;
  logic [3:0]    strb;
  logic [AW-3:0] addr_word;

  logic [AW-3:0] dp_word;
  logic [3:0]    dp_strb;
  logic          dp_write;
  logic [31:0]   hrdata_q;
  logic [31:0]   rd_fwd;

  logic [31:0]   mem [DEPTH];

  logic          unused_ctrl;
  assign unused_ctrl = ^{ahb.hburst, ahb.hport, ahb.hmastlock};

  assign addr_word  = ahb.haddr[AW-1:2];
  assign can_accept = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign accept     = ahb.hsel & ahb.hready & ahb.htrans[1] & can_accept;
  assign commit     = (state == ST_LAST) & dp_write;

  always_comb begin
    illegal = 1'b0;
    if (ahb.hsize > 3'd2)
      illegal = 1'b1;
    else if ((ahb.hsize == 3'd1) && ahb.haddr[0])
      illegal = 1'b1;
    else if ((ahb.hsize == 3'd2) && (ahb.haddr[1:0] != 2'b00))
      illegal = 1'b1;
  end

  always_comb begin
    strb = '1;
    case (ahb.hsize[1:0])
      2'd0:    strb = 4'b0001 << ahb.haddr[1:0];
      2'd1:    strb = ahb.haddr[1] ? 4'b1100 : 4'b0011;
      default: strb = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
            cnt_nxt   = '0;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end else begin
            state_nxt = ST_LAST;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = ST_LAST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ahb.hreadyout = ~((state == ST_WAIT) || (state == ST_ERR1));
  assign ahb.hresp     = (state == ST_ERR1) || (state == ST_ERR2);
  assign ahb.hrdata    = hrdata_q;

  // A read accepted on the edge that commits a write to the same word sees the new lanes.
  always_comb begin
    rd_fwd = mem[addr_word];
    for (int unsigned i = 0; i < 4; i++) begin
      if (commit && (dp_word == addr_word) && dp_strb[i])
        rd_fwd[8*i +: 8] = ahb.hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_word  <= '0;
      dp_strb  <= '0;
      dp_write <= 1'b0;
      hrdata_q <= '0;
    end else if (accept) begin
      dp_word  <= addr_word;
      dp_strb  <= strb;
      dp_write <= ahb.hwrite & ~illegal;
      if (!ahb.hwrite && !illegal)
        hrdata_q <= rd_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dp_strb[i])
          mem[dp_word][8*i +: 8] <= ahb.hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_sram.sv
// Randomised bench for two ahblite_sram instances (0 and 2 wait states) against a
// transfer-level memory model; directed sequences cover forwarding, lanes, errors and reset.
module tb_ahblite_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_v [2];
  logic [15:0] t_addr;
  logic [1:0]  t_trans;
  logic        t_write;
  logic [2:0]  t_size;
  logic [31:0] t_wdata;
  logic        hr_block = 1'b0;

  logic [1:0]  ro;
  logic [1:0]  rp;
  logic [31:0] rd [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahblite_sram_if #(.AW(16)) bus0 ();
  ahblite_sram_if #(.AW(16)) bus1 ();

  assign bus0.hsel      = sel_v[0];
  assign bus1.hsel      = sel_v[1];
  assign bus0.haddr     = t_addr;
  assign bus1.haddr     = t_addr;
  assign bus0.htrans    = t_trans;
  assign bus1.htrans    = t_trans;
  assign bus0.hwrite    = t_write;
  assign bus1.hwrite    = t_write;
  assign bus0.hsize     = t_size;
  assign bus1.hsize     = t_size;
  assign bus0.hburst    = 3'd0;
  assign bus1.hburst    = 3'd1;
  assign bus0.hport     = 4'h3;
  assign bus1.hport     = 4'h1;
  assign bus0.hmastlock = 1'b0;
  assign bus1.hmastlock = 1'b0;
  assign bus0.hwdata    = t_wdata;
  assign bus1.hwdata    = t_wdata;
  assign bus0.hready    = bus0.hreadyout & ~hr_block;
  assign bus1.hready    = bus1.hreadyout & ~hr_block;

  assign ro    = {bus1.hreadyout, bus0.hreadyout};
  assign rp    = {bus1.hresp, bus0.hresp};
  assign rd[0] = bus0.hrdata;
  assign rd[1] = bus1.hrdata;

  ahblite_sram #(.AW(16), .WAIT_STATES(0)) u_iram (.clk(clk), .rst(rst), .ahb(bus0));
  ahblite_sram #(.AW(16), .WAIT_STATES(2)) u_dram (.clk(clk), .rst(rst), .ahb(bus1));

  typedef struct {
    bit          valid;
    bit          err;
    bit          wr;
    logic [7:0]  a;
    logic [2:0]  sz;
    logic [31:0] wd;
  } xfer_t;

  xfer_t       pend;
  logic [31:0] mdl [2][64];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  function automatic logic [31:0] lane_mask(input logic [7:0] a, input logic [2:0] sz);
    case (sz)
      3'd0:    return 32'h0000_00FF << (8 * a[1:0]);
      3'd1:    return 32'h0000_FFFF << (16 * a[1]);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [7:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  // Drives one address phase while completing the pending data phase, then advances the model.
  task automatic step(input int inst, input bit sel, input logic [1:0] trans, input bit wr,
                      input logic [7:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int   n;
    int   ws;
    bit   done;
    logic e_ro;
    logic e_rp;
    logic [31:0] m;
    ws            = (inst == 1) ? 2 : 0;
    sel_v[inst]   = sel;
    sel_v[1-inst] = 1'b0;
    t_addr        = {8'h00, a};
    t_trans       = trans;
    t_write       = wr;
    t_size        = sz;
    t_wdata       = pend.wd;
    n             = 0;
    done          = 1'b0;
    while (!done) begin
      @(negedge clk);
      e_ro = 1'b1;
      e_rp = 1'b0;
      if (pend.valid && pend.err) begin
        e_ro = (n != 0);
        e_rp = 1'b1;
      end else if (pend.valid) begin
        e_ro = (n >= ws);
      end
      check("hreadyout", 32'(ro[inst]), 32'(e_ro));
      check("hresp", 32'(rp[inst]), 32'(e_rp));
      check("hrdata", rd[inst], last_rd[inst]);
      done = ro[inst];
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n > ws + 3) begin
          check("data_phase_len", 32'(n), 32'(ws + 1));
          finish_sim();
        end
      end
    end
    if (pend.valid && !pend.err && pend.wr) begin
      m = lane_mask(pend.a, pend.sz);
      mdl[inst][pend.a[7:2]] = (mdl[inst][pend.a[7:2]] & ~m) | (pend.wd & m);
    end
    if (sel && trans[1]) begin
      pend.valid = 1'b1;
      pend.err   = is_illegal(a, sz);
      pend.wr    = wr;
      pend.a     = a;
      pend.sz    = sz;
      pend.wd    = wd;
      if (!pend.err && !wr)
        last_rd[inst] = mdl[inst][a[7:2]];
    end else begin
      pend.valid = 1'b0;
      pend.wd    = $urandom;
    end
  endtask

  task automatic drain(input int inst);
    step(inst, 1'b0, 2'd0, 1'b0, 8'h00, 3'd0, 32'h0);
  endtask

  task automatic rd_word(input int inst, input logic [7:0] a);
    step(inst, 1'b1, 2'd2, 1'b0, a, 3'd2, 32'h0);
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 32'(n_checks), 32'hFFFF_FFFF);
    finish_sim();
  end

  initial begin
    logic [7:0]  ra;
    logic [7:0]  prev_a;
    logic [2:0]  rsz;
    logic [1:0]  rtr;
    sel_v[0] = 1'b0;
    sel_v[1] = 1'b0;
    t_addr   = '0;
    t_trans  = 2'd0;
    t_write  = 1'b0;
    t_size   = 3'd0;
    t_wdata  = '0;
    pend     = '{valid: 1'b0, err: 1'b0, wr: 1'b0, a: 8'h00, sz: 3'd0, wd: 32'h0};
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = '0;
      for (int w = 0; w < 64; w++) mdl[i][w] = '0;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_hreadyout", 32'(ro[i]), 32'd1);
      check("rst_hresp", 32'(rp[i]), 32'd0);
      check("rst_hrdata", rd[i], 32'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++)
        step(i, 1'b1, 2'd2, 1'b1, 8'(w * 4), 3'd2, $urandom);
      drain(i);
    end

    // Write then back-to-back read (forwarded), then re-read from the array.
    step(0, 1'b1, 2'd2, 1'b1, 8'h10, 3'd2, 32'hDEAD_BEEF);
    rd_word(0, 8'h10);
    drain(0);
    rd_word(0, 8'h10);
    step(0, 1'b1, 2'd2, 1'b1, 8'h11, 3'd0, 32'h0000_AA00);
    rd_word(0, 8'h10);
    step(0, 1'b1, 2'd2, 1'b1, 8'h12, 3'd1, 32'h1234_0000);
    rd_word(0, 8'h10);
    drain(0);

    step(1, 1'b1, 2'd2, 1'b1, 8'h20, 3'd2, 32'h55AA_55AA);
    rd_word(1, 8'h20);
    drain(1);
    rd_word(1, 8'h20);
    drain(1);

    // Illegal transfers back to back, then confirm memory is untouched.
    step(0, 1'b1, 2'd2, 1'b0, 8'h02, 3'd2, 32'h0);
    step(0, 1'b1, 2'd2, 1'b1, 8'h05, 3'd1, 32'hFFFF_FFFF);
    drain(0);
    rd_word(0, 8'h04);

    step(0, 1'b1, 2'd1, 1'b1, 8'h10, 3'd2, 32'hFFFF_FFFF);
    step(0, 1'b0, 2'd2, 1'b1, 8'h10, 3'd2, 32'hFFFF_FFFF);
    drain(0);
    rd_word(0, 8'h10);
    drain(0);

    // hready held low by another slave: the selected NONSEQ write must be ignored.
    hr_block = 1'b1;
    sel_v[0] = 1'b1;
    t_addr   = 16'h0044;
    t_trans  = 2'd2;
    t_write  = 1'b1;
    t_size   = 3'd2;
    t_wdata  = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("blk_hreadyout", 32'(ro[0]), 32'd1);
      check("blk_hresp", 32'(rp[0]), 32'd0);
      @(posedge clk);
    end
    #1;
    hr_block = 1'b0;
    drain(0);
    rd_word(0, 8'h44);
    drain(0);

    // Reset in the data phase of a write drops it.
    step(0, 1'b1, 2'd2, 1'b1, 8'h30, 3'd2, 32'hCAFE_F00D);
    t_trans  = 2'd0;
    sel_v[0] = 1'b0;
    t_wdata  = 32'hCAFE_F00D;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_hreadyout", 32'(ro[i]), 32'd1);
      check("mid_rst_hresp", 32'(rp[i]), 32'd0);
      check("mid_rst_hrdata", rd[i], 32'h0);
      last_rd[i] = '0;
    end
    pend.valid = 1'b0;
    rd_word(0, 8'h30);
    drain(0);

    prev_a = 8'h00;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 300; k++) begin
        case ($urandom_range(0, 9))
          0:       rtr = 2'd0;
          1:       rtr = 2'd1;
          default: rtr = 2'($urandom_range(2, 3));
        endcase
        rsz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        ra  = ($urandom_range(0, 2) == 0) ? prev_a : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 4) != 0) begin
          if (rsz == 3'd1) ra[0] = 1'b0;
          if (rsz == 3'd2) ra[1:0] = 2'b00;
        end
        prev_a = ra;
        step(i, ($urandom_range(0, 7) != 0), rtr, 1'($urandom_range(0, 1)), ra, rsz, $urandom);
      end
      drain(i);
      for (int w = 0; w < 64; w += 9)
        rd_word(i, 8'(w * 4));
      drain(i);
    end

    finish_sim();
  end

endmodule
